// File: rtl/ram_copier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ram_copier                                                      |
// | Purpose  : Block-copy engine driving a single-port synchronous RAM;        |
// |            alternates READ/WRITE cycles, optional fill via                 |
// |            RAM_COPIER_FILL_EN.                                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ram_copier #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [15:0]          i_src,
  input  logic [15:0]          i_dst,
  input  logic [LEN_WIDTH-1:0] i_len,
  input  logic                 i_abort,
  input  logic                 i_fill,
  input  logic [15:0]          i_fill_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_mem_load,
  output logic [15:0]          o_mem_addr,
  output logic [15:0]          o_mem_data,
  input  logic [15:0]          i_mem_data
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_read  = 2'd1;
  localparam logic [1:0] c_st_write = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam logic [LEN_WIDTH-1:0] c_len_zero = '0;
  localparam logic [LEN_WIDTH-1:0] c_len_one  = LEN_WIDTH'(1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [15:0]          r_src;
  logic [15:0]          r_dst;
  logic [LEN_WIDTH-1:0] r_rem;
  logic                 w_fill_mode;
  logic                 w_fill_start;
  logic [15:0]          w_write_data;

`ifdef RAM_COPIER_FILL_EN
  logic        r_fill;
  logic [15:0] r_fill_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fill      <= 1'b0;
      r_fill_data <= 16'h0000;
    end else if (r_state == c_st_idle && i_start) begin
      r_fill      <= i_fill;
      r_fill_data <= i_fill_data;
    end
  end

  assign w_fill_mode  = r_fill;
  assign w_fill_start = i_fill;
  assign w_write_data = r_fill ? r_fill_data : i_mem_data;
`else
  // Fill ports exist for pin compatibility only; every transfer is a copy.
  logic w_unused_fill;
  assign w_unused_fill = ^{i_fill, i_fill_data};
  assign w_fill_mode   = 1'b0;
  assign w_fill_start  = 1'b0;
  assign w_write_data  = i_mem_data;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (i_start) begin
          if (i_len == c_len_zero) w_state_nxt = c_st_done;
          else if (w_fill_start)   w_state_nxt = c_st_write;
          else                     w_state_nxt = c_st_read;
        end
      end
      c_st_read: begin
        w_state_nxt = i_abort ? c_st_idle : c_st_write;
      end
      c_st_write: begin
        if (i_abort)                 w_state_nxt = c_st_idle;
        else if (r_rem == c_len_one) w_state_nxt = c_st_done;
        else if (w_fill_mode)        w_state_nxt = c_st_write;
        else                         w_state_nxt = c_st_read;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= c_st_idle;
      r_src   <= 16'h0000;
      r_dst   <= 16'h0000;
      r_rem   <= c_len_zero;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        c_st_idle: begin
          if (i_start) begin
            r_src <= i_src;
            r_dst <= i_dst;
            r_rem <= i_len;
          end
        end
        c_st_read:  r_src <= r_src + 16'd1;
        c_st_write: begin
          r_dst <= r_dst + 16'd1;
          r_rem <= r_rem - c_len_one;
        end
        default: ;
      endcase
    end
  end

  // Memory port is a pure decode so the RAM sees the address in the same cycle.
  assign o_busy     = (r_state != c_st_idle);
  assign o_done     = (r_state == c_st_done);
  assign o_mem_load = (r_state == c_st_write);
  assign o_mem_addr = (r_state == c_st_read)  ? r_src :
                      (r_state == c_st_write) ? r_dst : 16'h0000;
  assign o_mem_data = (r_state == c_st_write) ? w_write_data : 16'h0000;

endmodule
`default_nettype wire
